alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shifter.sv | 49 ++++
 rtl/alu_core.sv | 85 ++++++++
 tb/tb_alu_core.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU core and its shifter:
//   - ALU_WIDTH   : default datapath width
//   - FUNCT_*     : 4-bit operation codes presented on alu_core.funct
//   - shift_op_t  : shift flavour selected inside alu_core for alu_shifter
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  // Operation codes; every code above FUNCT_SRL is reserved and yields zero.
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0001;
  localparam logic [3:0] FUNCT_AND = 4'b0010;
  localparam logic [3:0] FUNCT_OR  = 4'b0011;
  localparam logic [3:0] FUNCT_XOR = 4'b0100;
  localparam logic [3:0] FUNCT_NOT = 4'b0101;
  localparam logic [3:0] FUNCT_SLA = 4'b0110;
  localparam logic [3:0] FUNCT_SRA = 4'b0111;
  localparam logic [3:0] FUNCT_SRL = 4'b1000;

  // Shift flavour; SLA is the same operation as a logical left shift.
  typedef enum logic [1:0] {
    SHIFT_SLA = 2'd0,
    SHIFT_SRA = 2'd1,
    SHIFT_SRL = 2'd2
  } shift_op_t;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
// Purely combinational 5-stage barrel shifter. Stage k shifts by 2**k when
// amt[k] is set, so any amount 0..31 is reached in five fixed steps.
//
// Ports:
//   a      in  [WIDTH-1:0]  value to shift
//   amt    in  [4:0]        shift amount (0 passes a unchanged)
//   op     in  shift_op_t   SHIFT_SLA / SHIFT_SRA / SHIFT_SRL
//   result out [WIDTH-1:0]  shifted value
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       amt,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] result
);

  // Fill bit for vacated MSBs on right shifts: the original sign for SRA,
  // zero for SRL. Taken from the unshifted operand so every stage agrees.
  logic fill;
  assign fill = (op == SHIFT_SRA) ? a[WIDTH-1] : 1'b0;

  logic [WIDTH-1:0] shifted;

  // NOTE: combinational blocks assign every output a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    shifted = a;
    for (int k = 0; k < 5; k++) begin
      if (amt[k]) begin
        if (op == SHIFT_SLA) begin
          shifted = shifted << (1 << k);
        end else begin
          // Logical right shift, then OR the fill into the vacated top bits.
          shifted = (shifted >> (1 << k))
                  | (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
        end
      end
    end
  end

  assign result = shifted;

endmodule : alu_shifter

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Single-cycle ALU with registered outputs. The result is formed
// combinationally from A, B and funct and captured on every rising clk edge;
// there is no enable or handshake, so latency is exactly one cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (out = 0, flagZ = 1)
//   A      in   [WIDTH-1:0] first operand / value to shift
//   B      in   [WIDTH-1:0] second operand / shift amount (B[4:0] only)
//   funct  in   [3:0]       operation select (FUNCT_* in alu_pkg)
//   out    out  [WIDTH-1:0] registered result
//   flagZ  out              registered flag, high when out is zero
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       funct,
  output logic [WIDTH-1:0] out,
  output logic             flagZ
);

  shift_op_t        shift_op;
  logic [WIDTH-1:0] shift_result;
  logic [WIDTH-1:0] result;

  // Shift flavour only matters when funct is a shift; SLA is a safe default.
  always_comb begin
    shift_op = SHIFT_SLA;
    case (funct)
      FUNCT_SRA: shift_op = SHIFT_SRA;
      FUNCT_SRL: shift_op = SHIFT_SRL;
      default:   shift_op = SHIFT_SLA;
    endcase
  end

  // Upper bits of B are deliberately not used as a shift amount.
  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .a      (A),
    .amt    (B[4:0]),
    .op     (shift_op),
    .result (shift_result)
  );

  // ADD/SUB wrap modulo 2**WIDTH; the same bits serve signed and unsigned use.
  always_comb begin
    result = '0;
    case (funct)
      FUNCT_ADD: result = A + B;
      FUNCT_SUB: result = A - B;
      FUNCT_AND: result = A & B;
      FUNCT_OR:  result = A | B;
      FUNCT_XOR: result = A ^ B;
      FUNCT_NOT: result = ~A;
      FUNCT_SLA,
      FUNCT_SRA,
      FUNCT_SRL: result = shift_result;
      default:   result = '0;   // reserved codes
    endcase
  end

  // flagZ is derived from the value being loaded, not from the old out, so
  // both registers always describe the same result.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      flagZ <= 1'b1;
    end else begin
      out   <= result;
      flagZ <= (result == '0);
    end
  end

endmodule : alu_core

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Scoreboard bench for alu_core: the stimulus process pushes the expected
// result of each issued operation into a queue; the monitor pops and compares
// one entry per rising edge while reset is released.
// -----------------------------------------------------------------------------
module tb_alu_core;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [3:0]   funct = 4'd0;
  logic [W-1:0] out;
  logic         flagZ;

  typedef struct {
    logic [W-1:0] value;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .funct (funct),
    .out   (out),
    .flagZ (flagZ)
  );

  always #5 clk = ~clk;

  // Reference model: straight arithmetic on the operation's definition.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [3:0]   f);
    int unsigned         sh;
    logic signed [W-1:0] sa;
    sh = b % 32;
    sa = a;
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << sh;
      4'd7:    return sa >>> sh;
      4'd8:    return a >> sh;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one operation between edges and record its expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f, input string name);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    funct = f;
    e.value = ref_model(a, b, f);
    e.name  = name;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume every outstanding expectation.
  task automatic drain();
    int cycles;
    cycles = 0;
    while (sb.size() > 0 && cycles < 10) begin
      @(posedge clk);
      #2;
      cycles++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", W'(sb.size()), '0);
      sb.delete();
    end
  endtask

  // Monitor: the DUT presents a new result on every edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "_out"}, out, e.value);
        check({e.name, "_z"}, W'(flagZ), W'(e.value == '0));
      end
    end
  end

  initial begin
    // Asynchronous reset assertion, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out", out, '0);
    check("rst_async_z", W'(flagZ), W'(1));
    A = 32'd9; B = 32'd9;   // would give nonzero if reset were ignored
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out", out, '0);
    check("rst_hold_z", W'(flagZ), W'(1));

    // Release between edges: outputs must not move until the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_hold_out", out, '0);
    check("rel_hold_z", W'(flagZ), W'(1));

    // Directed vectors.
    issue(32'd5,          32'd7,          FUNCT_ADD, "add_5_7");
    issue(32'd12,         32'd7,          FUNCT_XOR, "xor_12_7");
    issue(32'hFFFF_FFF6,  32'd5,          FUNCT_SUB, "sub_m10_5");
    issue(32'd16,         32'd1,          FUNCT_SLA, "sla_16_1");
    issue(32'hAAAA_AAAA,  32'hCCCC_CCCC,  FUNCT_AND, "and_ac");
    issue(32'hAAAA_AAAA,  32'hCCCC_CCCC,  FUNCT_OR,  "or_ac");
    issue(32'hFFFF_FFF4,  32'd1,          FUNCT_SRA, "sra_m12_1");
    issue(32'hAAAA_AAAA,  32'd1,          FUNCT_SRL, "srl_a_1");
    issue(32'hAAAA_AAAA,  32'd33,         FUNCT_SRL, "srl_a_33");
    issue(32'd15,         32'd15,         FUNCT_XOR, "xor_zero");
    issue(32'hDEAD_BEEF,  32'h1234_5678,  4'b1111,   "rsvd_f");
    issue(32'h0F0F_0000,  32'hFFFF_FFFF,  FUNCT_NOT, "not");
    issue(32'h8000_0001,  32'hFFFF_FFE0,  FUNCT_SRA, "sra_amt0");
    issue(32'h8000_0000,  32'd31,         FUNCT_SRA, "sra_31");
    issue(32'h8000_0000,  32'd31,         FUNCT_SRL, "srl_31");
    issue(32'h0000_0001,  32'd31,         FUNCT_SLA, "sla_31");
    issue(32'hFFFF_FFFF,  32'd1,          FUNCT_ADD, "add_wrap");
    issue(32'd0,          32'd1,          FUNCT_SUB, "sub_wrap");
    issue(32'h1234_5678,  32'h0,          4'b1001,   "rsvd_9");
    drain();

    // Inputs changed between edges must not reach the outputs early.
    issue(32'd1, 32'd2, FUNCT_ADD, "pre_change");
    @(posedge clk);
    #3;
    A = 32'd100;
    #1;
    check("between_edges_out", out, 32'd3);
    check("between_edges_z", W'(flagZ), W'(0));

    // Reset mid-operation: discard immediately, hold across release.
    issue(32'h1234, 32'd0, FUNCT_OR, "pre_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out, '0);
    check("mid_rst_z", W'(flagZ), W'(1));
    @(negedge clk);
    A = 32'h55; B = 32'h1; funct = FUNCT_ADD;   // pending, never loaded
    @(posedge clk);
    #2;
    check("rst_discard_out", out, '0);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rel_out", out, '0);
    check("mid_rel_z", W'(flagZ), W'(1));
    issue(32'd3, 32'd4, FUNCT_ADD, "first_after_rst");

    // Randomized operations, including reserved codes and wide shift amounts.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rf;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 31)) : W'($urandom);
      rf = 4'($urandom_range(0, 15));
      if (i % 17 == 0) rb = ra;   // exercise zero results on SUB/XOR
      issue(ra, rb, rf, $sformatf("rnd%0d_f%0d", i, rf));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_core
